// File: rtl/player_shot_ctrl.sv
// Player laser shot: launches on fire press at the cannon, climbs SHOT_SPEED px per frame, retires off-top or on hit.
// Latency: shot_active/shot_x/shot_y/shot_fired update 1 cycle after the launching fire_btn sample.
// Backpressure: none; presses while a shot is in flight are dropped. Optional PLAYER_SHOT_AUTOFIRE_EN enables level-triggered refire.
module player_shot_ctrl #(
  parameter int XW         = 10,
  parameter int YW         = 10,
  parameter int PLAYER_Y   = 440,
  parameter int SHOT_H     = 8,
  parameter int X_OFFSET   = 7,
  parameter int SHOT_SPEED = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          fire_btn,
  input  logic          frame_tick,
  input  logic [XW-1:0] player_x,
  input  logic          hit,
  output logic          shot_active,
  output logic [XW-1:0] shot_x,
  output logic [YW-1:0] shot_y,
  output logic          shot_fired
);

  localparam logic [YW-1:0] LAUNCH_Y = YW'(PLAYER_Y - SHOT_H);
  localparam logic [XW-1:0] X_OFF    = XW'(X_OFFSET);
  localparam logic [YW-1:0] SPEED    = YW'(SHOT_SPEED);

  typedef enum logic {
    IDLE,
    FLYING
  } state_t;

  state_t        state, state_nxt;
  logic [XW-1:0] shot_x_nxt;
  logic [YW-1:0] shot_y_nxt;
  logic          shot_fired_nxt;
  logic          fire_q;
  logic          launch;

  // Previous button level; resets high so a press held through reset is not a fresh edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fire_q <= 1'b1;
    else        fire_q <= fire_btn;
  end

`ifdef PLAYER_SHOT_AUTOFIRE_EN
  logic armed;

  // Arms level-triggered fire once the button has been seen released after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       armed <= 1'b0;
    else if (!fire_q) armed <= 1'b1;
  end

  assign launch = fire_btn & (~fire_q | armed);
`else
  assign launch = fire_btn & ~fire_q;
`endif

  // State and shot registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      shot_x     <= '0;
      shot_y     <= '0;
      shot_fired <= 1'b0;
    end else begin
      state      <= state_nxt;
      shot_x     <= shot_x_nxt;
      shot_y     <= shot_y_nxt;
      shot_fired <= shot_fired_nxt;
    end
  end

  // Next-state: launch from IDLE; in flight, hit beats frame_tick, and an off-top shot retires instead of wrapping.
  always_comb begin
    state_nxt      = state;
    shot_x_nxt     = shot_x;
    shot_y_nxt     = shot_y;
    shot_fired_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (launch) begin
          state_nxt      = FLYING;
          shot_x_nxt     = player_x + X_OFF;
          shot_y_nxt     = LAUNCH_Y;
          shot_fired_nxt = 1'b1;
        end
      end
      FLYING: begin
        if (hit) begin
          state_nxt = IDLE;
        end else if (frame_tick) begin
          if (shot_y < SPEED) state_nxt  = IDLE;
          else                shot_y_nxt = shot_y - SPEED;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign shot_active = (state == FLYING);

endmodule

// File: tb/tb_player_shot_ctrl.sv
module tb_player_shot_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       fire_btn;
  logic       frame_tick;
  logic [9:0] player_x;
  logic       hit;
  logic       shot_active;
  logic [9:0] shot_x;
  logic [9:0] shot_y;
  logic       shot_fired;

  int checks = 0;
  int errors = 0;

  // Reference model: shot described directly as "is a shot up, where is it".
  bit m_active;
  int m_x, m_y;
  bit m_fired;
  bit m_prev_btn;
  bit m_seen_release;

  player_shot_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fire_btn   (fire_btn),
    .frame_tick (frame_tick),
    .player_x   (player_x),
    .hit        (hit),
    .shot_active(shot_active),
    .shot_x     (shot_x),
    .shot_y     (shot_y),
    .shot_fired (shot_fired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_x = 0; m_y = 0; m_fired = 0;
    m_prev_btn = 1; m_seen_release = 0;
  endtask

  task automatic model_edge();
    bit want;
    bit fired;
    fired = 0;
`ifdef PLAYER_SHOT_AUTOFIRE_EN
    want = fire_btn && (!m_prev_btn || m_seen_release);
`else
    want = fire_btn && !m_prev_btn;
`endif
    if (!m_active) begin
      if (want) begin
        m_active = 1;
        m_x = (player_x + 7) % 1024;
        m_y = 440 - 8;
        fired = 1;
      end
    end else if (hit) begin
      m_active = 0;
    end else if (frame_tick) begin
      if (m_y < 4) m_active = 0;
      else m_y = m_y - 4;
    end
    m_fired = fired;
    if (!m_prev_btn) m_seen_release = 1;
    m_prev_btn = fire_btn;
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, ".active"}, int'(shot_active), int'(m_active));
    chk({tag, ".x"},      int'(shot_x),      m_x);
    chk({tag, ".y"},      int'(shot_y),      m_y);
    chk({tag, ".fired"},  int'(shot_fired),  int'(m_fired));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge();
    #1;
    cmp_model(tag);
  endtask

  task automatic press(input logic [9:0] px);
    fire_btn = 0; step("release");
    fire_btn = 1; player_x = px; step("press");
  endtask

  initial begin
    rst_n = 0; fire_btn = 0; frame_tick = 0; player_x = 0; hit = 0;
    model_reset();
    #3;
    cmp_model("reset");
    repeat (2) step("in_reset");
    #3 rst_n = 1;
    step("post_reset");

    // Held press from player_x=100.
    press(10'd100);
    chk("held.active", int'(shot_active), 1);
    chk("held.x", int'(shot_x), 107);
    chk("held.y", int'(shot_y), 432);
    chk("held.fired", int'(shot_fired), 1);
    step("held.next");
    chk("held.fired_drop", int'(shot_fired), 0);
    repeat (5) step("held.hold");

    // Flight to top: 108 ticks to y=0, the next retires.
    frame_tick = 1;
    repeat (108) step("flight");
    chk("top.y0", int'(shot_y), 0);
    chk("top.still_active", int'(shot_active), 1);
    step("top.retire");
    chk("top.retired", int'(shot_active), 0);
    chk("top.no_underflow", int'(shot_y), 0);
    frame_tick = 0;

    // Hit priority at y=200.
    press(10'd300);
    frame_tick = 1;
    repeat (58) step("hp.climb");
    chk("hp.y200", int'(shot_y), 200);
    hit = 1;
    step("hp.hit");
    hit = 0; frame_tick = 0;
    chk("hp.inactive", int'(shot_active), 0);
    chk("hp.y_held", int'(shot_y), 200);

    // Presses during flight are dropped; a later press launches normally.
    press(10'd50);
    fire_btn = 0; player_x = 10'd600; step("ign.rel");
    fire_btn = 1; step("ign.press");
    chk("ign.no_fire", int'(shot_fired), 0);
    chk("ign.x", int'(shot_x), 57);
    hit = 1; step("ign.hit"); hit = 0;
    press(10'd1020);
    chk("ign.relaunch_x_wrap", int'(shot_x), 3);
    chk("ign.relaunch_fired", int'(shot_fired), 1);

    // Async reset mid-pulse, held button across release.
    hit = 1; step("ar.hit"); hit = 0;
    press(10'd200);
    #3 rst_n = 0;
    #1;
    model_reset();
    chk("ar.active", int'(shot_active), 0);
    chk("ar.fired", int'(shot_fired), 0);
    chk("ar.y", int'(shot_y), 0);
    chk("ar.x", int'(shot_x), 0);
    step("ar.low");
    #3 rst_n = 1;
    repeat (4) step("ar.held");
    chk("ar.no_launch", int'(shot_active), 0);
    press(10'd10);
    chk("ar.launch", int'(shot_active), 1);

`ifdef PLAYER_SHOT_AUTOFIRE_EN
    // Autofire: retire by hit while held, relaunch one cycle later.
    hit = 1; step("af.hit"); hit = 0;
    chk("af.idle", int'(shot_active), 0);
    step("af.relaunch");
    chk("af.fired", int'(shot_fired), 1);
    chk("af.y", int'(shot_y), 432);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) fire_btn = ~fire_btn;
      frame_tick = ($urandom_range(0, 3) == 0);
      hit = ($urandom_range(0, 15) == 0);
      player_x = 10'($urandom);
      if ($urandom_range(0, 999) == 0) begin
        #2 rst_n = 0;
        #1 model_reset();
        cmp_model("rnd.arst");
        step("rnd.rst");
        #2 rst_n = 1;
      end
      step("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
